// File: rtl/dataram_pkg.sv
// dataram_pkg
//   Shared types and constants for the DATARAM bus initiator:
//   request opcodes, FSM state encoding, default bit-area base,
//   idle bus values and small opcode-decode helpers.
package dataram_pkg;

  typedef enum logic [2:0] {
    OP_BYTE_RD = 3'd0,
    OP_BYTE_WR = 3'd1,
    OP_BIT_RD  = 3'd2,
    OP_BIT_WR  = 3'd3,
    OP_RN_RD   = 3'd4,
    OP_RN_WR   = 3'd5,
    OP_IND_RD  = 3'd6,
    OP_IND_WR  = 3'd7
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR1 = 3'd1,
    S_PTR2 = 3'd2,
    S_RD1  = 3'd3,
    S_RD2  = 3'd4,
    S_WR   = 3'd5,
    S_RSP  = 3'd6
  } state_e;

  localparam logic [7:0] BIT_BASE_DEFAULT = 8'h20;

  localparam logic       IDLE_CS       = 1'b1;
  localparam logic       IDLE_RW       = 1'b1;
  localparam logic       IDLE_BB       = 1'b1;
  localparam logic [7:0] IDLE_ADDR     = 8'h00;
  localparam logic [7:0] IDLE_POSITION = 8'h00;
  localparam logic [7:0] IDLE_DIN      = 8'h00;
  localparam logic       IDLE_BIN      = 1'b0;

  // Opcode LSB distinguishes write from read for every op family.
  function automatic logic op_is_write(input req_op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_bit(input req_op_e op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_rn(input req_op_e op);
    return (op[2:1] == 2'b10);
  endfunction

  function automatic logic op_is_ind(input req_op_e op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/dataram_bitaddr.sv
// dataram_bitaddr
//   Combinational mapping of an 8-bit bit address onto the
//   bit-addressable byte area.
//   i_bit_addr  : bit address (bit 7 set = outside the bit area)
//   o_byte_addr : BIT_BASE + i_bit_addr[6:3], 8-bit wrap
//   o_position  : one-hot bit position within the byte
//   o_err       : bit address >= 8'h80
module dataram_bitaddr
  import dataram_pkg::*;
#(
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEFAULT
) (
  input  logic [7:0] i_bit_addr,
  output logic [7:0] o_byte_addr,
  output logic [7:0] o_position,
  output logic       o_err
);

  assign o_byte_addr = BIT_BASE + {4'b0000, i_bit_addr[6:3]};
  assign o_position  = 8'h01 << i_bit_addr[2:0];
  assign o_err       = i_bit_addr[7];

endmodule

// File: rtl/dataram_master.sv
// dataram_master
//   Single-outstanding bus initiator for DATARAM. Accepts a request in
//   IDLE, forms the RAM address (direct, Rn banked, @Ri indirect, or bit),
//   drives a registered RAM bus and returns a one-cycle response.
//   clk, reset (async, active low)
//   req_*  : request handshake and payload from the core
//   rsp_*  : one-cycle response pulse and read result
//   ram_*  : registered DATARAM interface (ram_dout/ram_bout are inputs)
//
//   state | meaning
//   IDLE  | ready for a request, bus idle
//   PTR1  | pointer read cycle 1 (@Ri)
//   PTR2  | pointer read cycle 2, pointer captured at end
//   RD1   | data read cycle 1
//   RD2   | data read cycle 2, read data captured at end
//   WR    | single write cycle
//   RSP   | response pulse, bus idle
module dataram_master
  import dataram_pkg::*;
#(
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_bit,
  input  logic [1:0] rs,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_bit,
  output logic       rsp_err,
  output logic       ram_cs,
  output logic       ram_rw,
  output logic       ram_bb,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_position,
  output logic [7:0] ram_din,
  output logic       ram_bin,
  input  logic [7:0] ram_dout,
  input  logic       ram_bout
);

  state_e     r_state, w_state_nxt;
  req_op_e    r_op;
  logic [7:0] r_data;

  logic       r_cs, r_rw, r_bb, r_bin;
  logic [7:0] r_addr, r_pos, r_din;
  logic       w_cs, w_rw, w_bb, w_bin;
  logic [7:0] w_addr, w_pos, w_din;

  logic       r_rsp_valid, r_rsp_bit, r_rsp_err;
  logic [7:0] r_rsp_data;
  logic       w_rsp_valid, w_rsp_bit, w_rsp_err;
  logic [7:0] w_rsp_data;

  req_op_e    w_op;
  logic       w_accept;
  logic [7:0] w_bit_byte, w_bit_pos;
  logic       w_bit_err;

  assign w_op     = req_op_e'(req_op);
  assign w_accept = req_valid && (r_state == S_IDLE);

  dataram_bitaddr #(.BIT_BASE(BIT_BASE)) u_bitaddr (
    .i_bit_addr  (req_addr),
    .o_byte_addr (w_bit_byte),
    .o_position  (w_bit_pos),
    .o_err       (w_bit_err)
  );

  // Next bus values are computed for the state being entered so that the
  // RAM pins come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_cs        = IDLE_CS;
    w_rw        = IDLE_RW;
    w_bb        = IDLE_BB;
    w_addr      = IDLE_ADDR;
    w_pos       = IDLE_POSITION;
    w_din       = IDLE_DIN;
    w_bin       = IDLE_BIN;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 8'h00;
    w_rsp_bit   = 1'b0;
    w_rsp_err   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op_is_bit(w_op) && w_bit_err) begin
            w_state_nxt = S_RSP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else if (op_is_ind(w_op)) begin
            w_state_nxt = S_PTR1;
            w_cs        = 1'b0;
            w_addr      = {3'b000, rs, 2'b00, req_addr[0]};
          end else begin
            w_state_nxt = op_is_write(w_op) ? S_WR : S_RD1;
            w_cs        = 1'b0;
            w_rw        = ~op_is_write(w_op);
            if (op_is_bit(w_op)) begin
              w_bb   = 1'b0;
              w_addr = w_bit_byte;
              w_pos  = w_bit_pos;
              w_bin  = op_is_write(w_op) ? req_bit : 1'b0;
            end else begin
              w_addr = op_is_rn(w_op) ? {3'b000, rs, req_addr[2:0]} : req_addr;
              w_din  = op_is_write(w_op) ? req_data : 8'h00;
            end
          end
        end
      end
      S_PTR1, S_RD1: begin
        w_state_nxt = (r_state == S_PTR1) ? S_PTR2 : S_RD2;
        w_cs        = r_cs;
        w_rw        = r_rw;
        w_bb        = r_bb;
        w_addr      = r_addr;
        w_pos       = r_pos;
        w_din       = r_din;
        w_bin       = r_bin;
      end
      S_PTR2: begin
        // Pointer byte goes directly into the data-phase address.
        w_state_nxt = op_is_write(r_op) ? S_WR : S_RD1;
        w_cs        = 1'b0;
        w_rw        = ~op_is_write(r_op);
        w_addr      = ram_dout;
        w_din       = op_is_write(r_op) ? r_data : 8'h00;
      end
      S_RD2: begin
        w_state_nxt = S_RSP;
        w_rsp_valid = 1'b1;
        if (op_is_bit(r_op)) w_rsp_bit  = ram_bout;
        else                 w_rsp_data = ram_dout;
      end
      S_WR: begin
        w_state_nxt = S_RSP;
        w_rsp_valid = 1'b1;
      end
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_BYTE_RD;
      r_data      <= 8'h00;
      r_cs        <= IDLE_CS;
      r_rw        <= IDLE_RW;
      r_bb        <= IDLE_BB;
      r_addr      <= IDLE_ADDR;
      r_pos       <= IDLE_POSITION;
      r_din       <= IDLE_DIN;
      r_bin       <= IDLE_BIN;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_bit   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_accept) begin
        r_op   <= w_op;
        r_data <= req_data;
      end
      r_cs        <= w_cs;
      r_rw        <= w_rw;
      r_bb        <= w_bb;
      r_addr      <= w_addr;
      r_pos       <= w_pos;
      r_din       <= w_din;
      r_bin       <= w_bin;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_bit   <= w_rsp_bit;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_bit      = r_rsp_bit;
  assign rsp_err      = r_rsp_err;
  assign ram_cs       = r_cs;
  assign ram_rw       = r_rw;
  assign ram_bb       = r_bb;
  assign ram_addr     = r_addr;
  assign ram_position = r_pos;
  assign ram_din      = r_din;
  assign ram_bin      = r_bin;

endmodule

// File: tb/tb_dataram_master.sv
module tb_dataram_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_bit;
  logic [1:0] rs;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_bit;
  logic       rsp_err;
  logic       ram_cs;
  logic       ram_rw;
  logic       ram_bb;
  logic [7:0] ram_addr;
  logic [7:0] ram_position;
  logic [7:0] ram_din;
  logic       ram_bin;
  logic [7:0] ram_dout;
  logic       ram_bout;

  int checks   = 0;
  int failures = 0;

  dataram_master dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_bit      (req_bit),
    .rs           (rs),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_bit      (rsp_bit),
    .rsp_err      (rsp_err),
    .ram_cs       (ram_cs),
    .ram_rw       (ram_rw),
    .ram_bb       (ram_bb),
    .ram_addr     (ram_addr),
    .ram_position (ram_position),
    .ram_din      (ram_din),
    .ram_bin      (ram_bin),
    .ram_dout     (ram_dout),
    .ram_bout     (ram_bout)
  );

  always #5 clk = ~clk;

  // Behavioural DATARAM: asynchronous read, write on rising edge.
  logic [7:0] mem [256];
  logic       mem_clr;

  assign ram_dout = mem[ram_addr];
  assign ram_bout = |(mem[ram_addr] & ram_position);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (!ram_cs && !ram_rw) begin
      if (ram_bb) mem[ram_addr] <= ram_din;
      else        mem[ram_addr] <= (mem[ram_addr] & ~ram_position) |
                                   (ram_bin ? ram_position : 8'h00);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent transaction
  int         lat;
  logic [7:0] o_data;
  logic       o_bit, o_err, saw_cs;
  logic [7:0] first_addr, last_addr, last_pos;
  logic       last_bb;

  // Called on a falling edge; returns on a falling edge.
  task automatic run(input logic [2:0] op, input logic [7:0] addr,
                     input logic [7:0] dat, input logic b, input logic [1:0] rsv);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = dat;
    req_bit   = b;
    rs        = rsv;
    chk("ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rs        = 2'b11;
    req_addr  = 8'hFF;
    req_data  = 8'hFF;
    lat = 99; o_data = 8'h00; o_bit = 1'b0; o_err = 1'b0; saw_cs = 1'b0;
    first_addr = 8'h00; last_addr = 8'h00; last_pos = 8'h00; last_bb = 1'b1;
    for (int k = 1; k <= 12 && lat == 99; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_not_ready", req_ready, 0);
      if (!ram_cs) begin
        if (!saw_cs) first_addr = ram_addr;
        saw_cs    = 1'b1;
        last_addr = ram_addr;
        last_pos  = ram_position;
        last_bb   = ram_bb;
      end
      if (rsp_valid) begin
        lat    = k;
        o_data = rsp_data;
        o_bit  = rsp_bit;
        o_err  = rsp_err;
      end
    end
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_data", rsp_data, 0);
    chk("post_rsp_err", rsp_err, 0);
    chk("post_ready", req_ready, 1);
    chk("post_bus_idle", {ram_cs, ram_rw, ram_bb, ram_addr, ram_position, ram_din, ram_bin},
        {1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
  endtask

  logic saw_rsp;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00;
    req_data = 8'h00; req_bit = 1'b0; rs = 2'b00; mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_bit, rsp_err}, 0);
    chk("rst_bus", {ram_cs, ram_rw, ram_bb, ram_addr, ram_position, ram_din, ram_bin},
        {1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
    mem_clr = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    // Byte write then read
    run(3'd1, 8'h45, 8'hA5, 1'b0, 2'b00);
    chk("bwr_lat", lat, 2);
    chk("bwr_addr", last_addr, 8'h45);
    chk("bwr_data", o_data, 8'h00);
    run(3'd0, 8'h45, 8'h00, 1'b0, 2'b00);
    chk("brd_lat", lat, 3);
    chk("brd_data", o_data, 8'hA5);
    chk("brd_bb", last_bb, 1);

    // Rn banking; rs is scrambled right after accept inside run()
    run(3'd5, 8'h03, 8'h3C, 1'b0, 2'b10);
    chk("rnwr_lat", lat, 2);
    chk("rnwr_addr", last_addr, 8'h13);
    run(3'd4, 8'h03, 8'h00, 1'b0, 2'b00);
    chk("rnrd0_addr", last_addr, 8'h03);
    chk("rnrd0_data", o_data, 8'h00);
    run(3'd4, 8'h03, 8'h00, 1'b0, 2'b10);
    chk("rnrd2_lat", lat, 3);
    chk("rnrd2_data", o_data, 8'h3C);

    // Bit access
    run(3'd3, 8'h0B, 8'h00, 1'b1, 2'b00);
    chk("bitwr_lat", lat, 2);
    chk("bitwr_addr", last_addr, 8'h21);
    chk("bitwr_pos", last_pos, 8'h08);
    chk("bitwr_bb", last_bb, 0);
    run(3'd2, 8'h0B, 8'h00, 1'b0, 2'b00);
    chk("bitrd_lat", lat, 3);
    chk("bitrd_bit", o_bit, 1);
    chk("bitrd_data", o_data, 8'h00);
    run(3'd0, 8'h21, 8'h00, 1'b0, 2'b00);
    chk("bitbyte_data", o_data, 8'h08);
    run(3'd2, 8'h0C, 8'h00, 1'b0, 2'b00);
    chk("bitrd_clear", o_bit, 0);
    chk("bitrd_clear_pos", last_pos, 8'h10);

    // Indirect through R1 of bank 0
    run(3'd5, 8'h01, 8'h90, 1'b0, 2'b00);
    chk("r1wr_addr", last_addr, 8'h01);
    run(3'd7, 8'h01, 8'h5A, 1'b0, 2'b00);
    chk("indwr_lat", lat, 4);
    chk("indwr_ptr_addr", first_addr, 8'h01);
    chk("indwr_data_addr", last_addr, 8'h90);
    run(3'd6, 8'h01, 8'h00, 1'b0, 2'b00);
    chk("indrd_lat", lat, 5);
    chk("indrd_data", o_data, 8'h5A);
    chk("indrd_data_addr", last_addr, 8'h90);

    // Bit address out of range
    run(3'd2, 8'h85, 8'h00, 1'b0, 2'b00);
    chk("err_lat", lat, 1);
    chk("err_flag", o_err, 1);
    chk("err_no_cs", saw_cs, 0);

    // Reset asserted during RD2
    req_valid = 1'b1; req_op = 3'd0; req_addr = 8'h45; rs = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rd1_cs_low", ram_cs, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_bus", {ram_cs, ram_rw, ram_bb, ram_addr, ram_position}, {1'b1, 1'b1, 1'b1, 8'h00, 8'h00});
    chk("midrst_rsp", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("midrst_no_rsp", saw_rsp, 0);
    chk("midrst_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dataram_master.md
# dataram_master

Bus initiator for the DATARAM internal data memory. Sits between the instruction-execution core and DATARAM. Accepts one memory request at a time from the core and sequences DATARAM's chip-select/read-write/byte-bit interface:
- direct byte access;
- working-register Rn access through the PSW bank bits;
- indirect @Ri access, which reads the pointer from Rn and then accesses the target byte;
- bit-addressable access.

Returns read data as a one-cycle response pulse.

## Interface
- `BIT_BASE`, default 8'h20: byte address of bit 0x00 in the bit-addressable area.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request; high only in IDLE.
- `req_op`, input, 3: operation code, one of
  - `BYTE_RD`=0, `BYTE_WR`=1, `BIT_RD`=2, `BIT_WR`=3, `RN_RD`=4, `RN_WR`=5, `IND_RD`=6, `IND_WR`=7.
- `req_addr`, input, 8: direct byte address, bit address, or register index (Rn uses [2:0]; @Ri uses [0]).
- `req_data`, input, 8: byte write data.
- `req_bit`, input, 1: bit write data.
- `rs`, input, 2: PSW register-bank select; sampled at accept.
- `rsp_valid`, output, 1: one-cycle completion pulse. No backpressure.
- `rsp_data`, output, 8: byte read result. 0 for writes and bit ops.
- `rsp_bit`, output, 1: bit read result. 0 otherwise.
- `rsp_err`, output, 1: bit address ≥ 8'h80. No RAM access is performed.
- `ram_cs`, output, 1: DATARAM CS, active low.
- `ram_rw`, output, 1: DATARAM RW; 1 = read, 0 = write.
- `ram_bb`, output, 1: DATARAM Bb; 1 = byte, 0 = bit.
- `ram_addr`, output, 8: DATARAM address.
- `ram_position`, output, 8: one-hot bit position for bit ops; 0 for byte ops.
- `ram_din`, output, 8: byte write data.
- `ram_bin`, output, 1: bit write data.
- `ram_dout`, input, 8: DATARAM byte read data.
- `ram_bout`, input, 1: DATARAM bit read data.

## Operation
- **Accept:** a request is accepted on a clock edge with `req_valid && req_ready`. `req_op`, `req_addr`, `req_data`, `req_bit` and `rs` are latched.
- **Address formation:**
  - Byte ops: `ram_addr = req_addr`.
  - Rn ops: `ram_addr = {3'b000, rs, req_addr[2:0]}`.
  - Bit ops: `ram_addr = BIT_BASE + req_addr[6:3]` (8-bit add, no carry out), `ram_position = 1 << req_addr[2:0]`, `ram_bb = 0`.
  - Bit op with `req_addr[7] = 1`: skips all RAM states, goes straight to RSP with `rsp_err = 1`.
- **Indirect ops:**
  - First, pointer read of `{3'b000, rs, 2'b00, req_addr[0]}`, byte mode.
  - The captured pointer (full 8 bits, 0x00–0xFF) becomes `ram_addr` for the data phase.
- **States:**
  - IDLE → PTR1 (indirect), RD1 (reads), WR (writes), or RSP (bit error).
  - PTR1 → PTR2 → RD1 or WR.
  - RD1 → RD2 → RSP.
  - WR → RSP.
  - RSP → IDLE.
- **Read phase (RD1/RD2, PTR1/PTR2):**
  - `ram_cs = 0`, `ram_rw = 1`; address and position are held stable for both cycles.
  - `ram_dout` / `ram_bout` are captured at the end of the second cycle.
- **Write (WR):** one cycle with `ram_cs = 0`, `ram_rw = 0`; `ram_din` / `ram_bin` valid.
  - Bit writes use the RAM's per-position select. No read-modify-write.
- **Idle bus value** (every state except PTR*, RD*, WR): `ram_cs = 1`, `ram_rw = 1`, `ram_bb = 1`, `ram_addr = 0`, `ram_position = 0`, `ram_din = 0`, `ram_bin = 0`.
- **Reset:**
  - Returns to IDLE and drives all RAM outputs to the idle bus value.
  - `rsp_*` = 0, `req_ready` = 1 after release.
  - Assertion mid-operation aborts with no response. A write interrupted during its WR cycle is not guaranteed to commit.

## Timing
Accept edge = T. `rsp_valid` is high during the cycle after:
- BYTE/BIT/RN read: T+3.
- BYTE/BIT/RN write: T+2.
- IND read: T+5.
- IND write: T+4.
- Bit error: T+1.

Further rules:
- `rsp_data`, `rsp_bit`, `rsp_err` are valid only while `rsp_valid` = 1 and return to 0 afterwards.
- `req_ready` = 0 from T+1 until the RSP cycle completes. The earliest next accept is the edge ending RSP+1 (IDLE).
- `rs` changes after accept have no effect on an in-flight request.
- RAM outputs are registered: they change only on clock edges or on asynchronous reset.

## Structure
- Package `dataram_pkg` holds:
  - the `req_op` enum;
  - the state enum;
  - `BIT_BASE_DEFAULT`;
  - the idle bus constants.
- One combinational sub-module, `dataram_bitaddr`. Input: bit address. Outputs: byte address, one-hot position, error flag.
- The FSM and bus registers stay in `dataram_master`.

## Test plan
- **Byte write then read:** `BYTE_WR` 8'h45 ← 8'hA5, then `BYTE_RD` 8'h45 → `rsp_data` = 8'hA5 at T+3; RAM bus back at idle values.
- **Rn banking:** `rs` = 2'b10, `RN_WR` R3 ← 8'h3C → `ram_addr` = 8'h13. `RN_RD` R3 with `rs` = 2'b00 shows `ram_addr` = 8'h03.
- **Bit access:** `BIT_WR` addr 8'h0B ← 1 → `ram_addr` = 8'h21, `ram_position` = 8'h08, `ram_bb` = 0. `BIT_RD` 8'h0B → `rsp_bit` = 1; `BYTE_RD` 8'h21 → bit 3 set.
- **Indirect:** R1 (bank 0) = 8'h90, then `IND_WR` @R1 ← 8'h5A, then `IND_RD` @R1 → `rsp_data` = 8'h5A at T+5; the data phase drives `ram_addr` = 8'h90.
- **Error and reset:** `BIT_RD` 8'h85 → `rsp_err` = 1 at T+1 with `ram_cs` never low. `reset` asserted during RD2 → bus idle immediately, no `rsp_valid`, `req_ready` = 1 after release.
